// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU system sequencer.
package alu_seq_pkg;

  localparam int unsigned IR_W   = 16;
  localparam int unsigned FLAG_W = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_FETCH_L = 3'd2,
    S_FETCH_H = 3'd3,
    S_DECODE  = 3'd4,
    S_EXEC    = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  // RF / ARF function codes
  localparam logic [2:0] FUN_DEC   = 3'b000;
  localparam logic [2:0] FUN_INC   = 3'b001;
  localparam logic [2:0] FUN_LOAD  = 3'b010;
  localparam logic [2:0] FUN_CLEAR = 3'b011;

  // ARF output D selects (memory address source)
  localparam logic [1:0] OUTD_PC = 2'b00;
  localparam logic [1:0] OUTD_AR = 2'b10;

  // Instruction classes, IR[15:14]
  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_LDI = 2'b01;
  localparam logic [1:0] CLS_LDM = 2'b10;
  localparam logic [1:0] CLS_CTL = 2'b11;

  // Mux selects
  localparam logic [1:0] MUXA_ALU = 2'b00;
  localparam logic [1:0] MUXA_MEM = 2'b10;
  localparam logic [1:0] MUXA_IMM = 2'b11;
  localparam logic [1:0] MUXB_IMM = 2'b11;

  localparam logic [2:0] ARF_SEL_PC = 3'b100;

  // Complete control bundle driven into the datapath
  typedef struct packed {
    logic [2:0] rf_outa_sel;
    logic [2:0] rf_outb_sel;
    logic [2:0] rf_fun_sel;
    logic [3:0] rf_reg_sel;
    logic [3:0] rf_scr_sel;
    logic [4:0] alu_fun_sel;
    logic       alu_wf;
    logic [1:0] arf_outc_sel;
    logic [1:0] arf_outd_sel;
    logic [2:0] arf_fun_sel;
    logic [2:0] arf_reg_sel;
    logic       ir_lh;
    logic       ir_write;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic       mux_c_sel;
  } ctl_t;

  // Register index 00..11 -> enable R1..R4 (bit3..bit0)
  function automatic logic [3:0] rf_onehot(input logic [1:0] idx);
    return 4'b1000 >> idx;
  endfunction

  // Nothing written, memory deselected
  function automatic ctl_t ctl_idle();
    ctl_t c;
    c        = '0;
    c.mem_cs = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational map from (state, IR, Z flag) to the datapath control bundle.
//   state  : current sequencer state
//   ir     : instruction register contents
//   z      : zero flag from the previous flag-writing ALU op
//   ctl_c  : control bundle (Moore w.r.t. state and IR)
module alu_seq_decode
  import alu_seq_pkg::*;
#(
  parameter logic [15:0] PC_START = 16'h0000
) (
  input  state_t          state,
  input  logic [IR_W-1:0] ir,
  input  logic            z,
  output ctl_t            ctl_c
);

  always_comb begin
    ctl_c = ctl_idle();
    unique case (state)
      S_INIT: begin
        ctl_c.arf_reg_sel = ARF_SEL_PC;
        // A non-zero start address is supplied on the MuxB constant path.
        if (PC_START != 16'h0000) begin
          ctl_c.arf_fun_sel = FUN_LOAD;
          ctl_c.mux_b_sel   = MUXB_IMM;
        end else begin
          ctl_c.arf_fun_sel = FUN_CLEAR;
        end
      end
      S_FETCH_L, S_FETCH_H: begin
        ctl_c.arf_outd_sel = OUTD_PC;
        ctl_c.mem_cs       = 1'b0;
        ctl_c.mem_wr       = 1'b0;
        ctl_c.ir_write     = 1'b1;
        ctl_c.ir_lh        = (state == S_FETCH_H);
        ctl_c.arf_reg_sel  = ARF_SEL_PC;
        ctl_c.arf_fun_sel  = FUN_INC;
      end
      S_EXEC: begin
        unique case (ir[15:14])
          CLS_ALU: begin
            ctl_c.alu_fun_sel = ir[13:9];
            ctl_c.rf_outa_sel = ir[5:3];
            ctl_c.rf_outb_sel = ir[2:0];
            ctl_c.alu_wf      = 1'b1;
            ctl_c.mux_a_sel   = MUXA_ALU;
            ctl_c.rf_fun_sel  = FUN_LOAD;
            ctl_c.rf_reg_sel  = rf_onehot(ir[7:6]);
          end
          CLS_LDI: begin
            ctl_c.mux_a_sel  = MUXA_IMM;
            ctl_c.rf_fun_sel = FUN_LOAD;
            ctl_c.rf_reg_sel = rf_onehot(ir[9:8]);
          end
          CLS_LDM: begin
            ctl_c.arf_outd_sel = OUTD_AR;
            ctl_c.mem_cs       = 1'b0;
            ctl_c.mem_wr       = 1'b0;
            ctl_c.mux_a_sel    = MUXA_MEM;
            ctl_c.rf_fun_sel   = FUN_LOAD;
            ctl_c.rf_reg_sel   = rf_onehot(ir[9:8]);
          end
          CLS_CTL: begin
            // BNZ: PC <- IR[7:0] when Z is clear; HALT drives nothing.
            if (ir[13] && !z) begin
              ctl_c.mux_b_sel   = MUXB_IMM;
              ctl_c.arf_fun_sel = FUN_LOAD;
              ctl_c.arf_reg_sel = ARF_SEL_PC;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_system_sequencer.sv
// Hardwired control unit for the ALU system datapath.
// Runs fetch (two byte reads) -> decode -> execute over a 16-bit ISA.
//   Clock, Reset (async active-low), Start (pulse from IDLE/HALT)
//   IROut, FlagsOut   : feedback from the datapath
//   RF_*, ALU_*, ARF_*, IR_*, Mem_*, Mux*Sel : datapath controls
//   Busy, Halted      : status; InstrCount : retired instructions
module alu_system_sequencer
  import alu_seq_pkg::*;
#(
  parameter logic [15:0] PC_START = 16'h0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [15:0]      IROut,
  input  logic [3:0]       FlagsOut,
  output logic [2:0]       RF_OutASel,
  output logic [2:0]       RF_OutBSel,
  output logic [2:0]       RF_FunSel,
  output logic [3:0]       RF_RegSel,
  output logic [3:0]       RF_ScrSel,
  output logic [4:0]       ALU_FunSel,
  output logic             ALU_WF,
  output logic [1:0]       ARF_OutCSel,
  output logic [1:0]       ARF_OutDSel,
  output logic [2:0]       ARF_FunSel,
  output logic [2:0]       ARF_RegSel,
  output logic             IR_LH,
  output logic             IR_Write,
  output logic             Mem_WR,
  output logic             Mem_CS,
  output logic [1:0]       MuxASel,
  output logic [1:0]       MuxBSel,
  output logic             MuxCSel,
  output logic             Busy,
  output logic             Halted,
  output logic [CNT_W-1:0] InstrCount
);

  state_t           state, state_n;
  logic             retire_c;
  ctl_t             ctl_c;
  logic             busy_q, halted_q;
  logic [CNT_W-1:0] cnt_q;
  logic             unused_flags;

  // Only Z steers control; the other flags are not consumed here.
  assign unused_flags = ^FlagsOut[2:0];

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic and retire strobe
  always_comb begin
    state_n  = state;
    retire_c = 1'b0;
    unique case (state)
      S_IDLE, S_HALT: if (Start) state_n = S_INIT;
      S_INIT:         state_n = S_FETCH_L;
      S_FETCH_L:      state_n = S_FETCH_H;
      S_FETCH_H:      state_n = S_DECODE;
      S_DECODE:       state_n = S_EXEC;
      S_EXEC: begin
        retire_c = 1'b1;
        if (IROut[15:14] == CLS_CTL && !IROut[13]) state_n = S_HALT;
        else                                       state_n = S_FETCH_L;
      end
      default:        state_n = S_IDLE;
    endcase
  end

  // Status flags track the state being entered, so they line up with it.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      busy_q   <= (state_n == S_FETCH_L) || (state_n == S_FETCH_H) ||
                  (state_n == S_DECODE)  || (state_n == S_EXEC);
      halted_q <= (state_n == S_HALT);
      if (retire_c) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  alu_seq_decode #(
    .PC_START (PC_START)
  ) u_decode (
    .state (state),
    .ir    (IROut),
    .z     (FlagsOut[3]),
    .ctl_c (ctl_c)
  );

  assign RF_OutASel  = ctl_c.rf_outa_sel;
  assign RF_OutBSel  = ctl_c.rf_outb_sel;
  assign RF_FunSel   = ctl_c.rf_fun_sel;
  assign RF_RegSel   = ctl_c.rf_reg_sel;
  assign RF_ScrSel   = ctl_c.rf_scr_sel;
  assign ALU_FunSel  = ctl_c.alu_fun_sel;
  assign ALU_WF      = ctl_c.alu_wf;
  assign ARF_OutCSel = ctl_c.arf_outc_sel;
  assign ARF_OutDSel = ctl_c.arf_outd_sel;
  assign ARF_FunSel  = ctl_c.arf_fun_sel;
  assign ARF_RegSel  = ctl_c.arf_reg_sel;
  assign IR_LH       = ctl_c.ir_lh;
  assign IR_Write    = ctl_c.ir_write;
  assign Mem_WR      = ctl_c.mem_wr;
  assign Mem_CS      = ctl_c.mem_cs;
  assign MuxASel     = ctl_c.mux_a_sel;
  assign MuxBSel     = ctl_c.mux_b_sel;
  assign MuxCSel     = ctl_c.mux_c_sel;
  assign Busy        = busy_q;
  assign Halted      = halted_q;
  assign InstrCount  = cnt_q;

endmodule

// File: tb/tb_alu_system_sequencer.sv
// Bench for alu_system_sequencer: a tiny IR/PC/memory model feeds IROut,
// expected EXEC bundles are queued when the program is loaded.
module tb_alu_system_sequencer;

  localparam int unsigned CW = 8;

  logic          Clock = 1'b0;
  logic          Reset, Start;
  logic [15:0]   IROut;
  logic [3:0]    FlagsOut;
  logic [2:0]    RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]    RF_RegSel, RF_ScrSel;
  logic [4:0]    ALU_FunSel;
  logic          ALU_WF;
  logic [1:0]    ARF_OutCSel, ARF_OutDSel;
  logic [2:0]    ARF_FunSel, ARF_RegSel;
  logic          IR_LH, IR_Write, Mem_WR, Mem_CS;
  logic [1:0]    MuxASel, MuxBSel;
  logic          MuxCSel, Busy, Halted;
  logic [CW-1:0] InstrCount;

  alu_system_sequencer #(.PC_START(16'h0000), .CNT_W(CW)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .IROut(IROut), .FlagsOut(FlagsOut),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel), .ALU_FunSel(ALU_FunSel),
    .ALU_WF(ALU_WF), .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH),
    .IR_Write(IR_Write), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel),
    .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .Busy(Busy), .Halted(Halted),
    .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [4:0] alu_fun;
    logic       alu_wf;
    logic [2:0] outa, outb, rf_fun;
    logic [3:0] rf_reg, scr;
    logic [1:0] muxa, muxb;
    logic       muxc;
    logic [1:0] arf_c, arf_d;
    logic [2:0] arf_fun, arf_reg;
    logic       ir_lh, ir_wr, mem_wr, mem_cs;
  } tctl_t;

  typedef struct packed {
    logic [15:0] instr;
    tctl_t       ctl;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mem [256];
  logic [15:0] ir_m;
  logic [7:0]  pc_m;
  int          checks = 0;
  int          failures = 0;
  int          exp_cnt = 0;

  function automatic tctl_t idle_c();
    tctl_t c;
    c = '0;
    c.mem_cs = 1'b1;
    return c;
  endfunction

  function automatic tctl_t act();
    tctl_t c;
    c.alu_fun = ALU_FunSel; c.alu_wf = ALU_WF;
    c.outa = RF_OutASel; c.outb = RF_OutBSel; c.rf_fun = RF_FunSel;
    c.rf_reg = RF_RegSel; c.scr = RF_ScrSel;
    c.muxa = MuxASel; c.muxb = MuxBSel; c.muxc = MuxCSel;
    c.arf_c = ARF_OutCSel; c.arf_d = ARF_OutDSel;
    c.arf_fun = ARF_FunSel; c.arf_reg = ARF_RegSel;
    c.ir_lh = IR_LH; c.ir_wr = IR_Write; c.mem_wr = Mem_WR; c.mem_cs = Mem_CS;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the IR/PC model reacts to the controls seen before the edge.
  task automatic tick();
    logic [15:0] nir;
    logic [7:0]  npc;
    nir = ir_m;
    npc = pc_m;
    if (IR_Write && !Mem_CS) begin
      if (IR_LH) nir[15:8] = mem[pc_m];
      else       nir[7:0]  = mem[pc_m];
    end
    if (ARF_RegSel[2]) begin
      case (ARF_FunSel)
        3'b011: npc = 8'h00;
        3'b001: npc = pc_m + 8'd1;
        3'b010: if (MuxBSel == 2'b11) npc = ir_m[7:0];
        default: ;
      endcase
    end
    @(posedge Clock);
    #1;
    ir_m  = nir;
    pc_m  = npc;
    IROut = ir_m;
  endtask

  task automatic put(input logic [7:0] addr, input logic [15:0] instr, input tctl_t c);
    exp_t e;
    mem[addr]        = instr[7:0];
    mem[addr + 8'd1] = instr[15:8];
    e.instr = instr;
    e.ctl   = c;
    sb.push_back(e);
  endtask

  // Walk one instruction from FETCH_L through EXEC, checking every phase.
  task automatic run_instr(input logic [3:0] flags);
    tctl_t f;
    exp_t  e;
    FlagsOut = flags;
    f = idle_c();
    f.ir_wr = 1'b1; f.mem_cs = 1'b0; f.arf_reg = 3'b100; f.arf_fun = 3'b001;
    chk("fetch_l_ctl", 64'(act()), 64'(f));
    chk("fetch_l_busy", 64'(Busy), 64'd1);
    tick();
    f.ir_lh = 1'b1;
    chk("fetch_h_ctl", 64'(act()), 64'(f));
    tick();
    chk("decode_ctl", 64'(act()), 64'(idle_c()));
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd0, 64'd1);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    chk("decode_ir", 64'(IROut), 64'(e.instr));
    tick();
    chk("exec_ctl", 64'(act()), 64'(e.ctl));
    tick();
    exp_cnt++;
    chk("instr_count", 64'(InstrCount), 64'(exp_cnt));
  endtask

  initial begin
    tctl_t c;
    tctl_t init_c;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    Reset = 1'b0; Start = 1'b0; FlagsOut = 4'h0; IROut = 16'h0000;
    ir_m = 16'h0000; pc_m = 8'h00;
    init_c = idle_c(); init_c.arf_reg = 3'b100; init_c.arf_fun = 3'b011;

    // Program, with expected EXEC bundles in execution order
    c = idle_c(); c.muxa = 2'b11; c.rf_fun = 3'b010; c.rf_reg = 4'b1000;
    put(8'h00, 16'h4005, c);                       // LDI R1,5
    c = idle_c(); c.alu_fun = 5'b00110; c.outa = 3'b010; c.outb = 3'b011;
    c.alu_wf = 1'b1; c.rf_fun = 3'b010; c.rf_reg = 4'b0100;
    put(8'h02, 16'h0C53, c);                       // ALU -> R2
    c = idle_c(); c.arf_d = 2'b10; c.mem_cs = 1'b0; c.muxa = 2'b10;
    c.rf_fun = 3'b010; c.rf_reg = 4'b0010;
    put(8'h04, 16'h8200, c);                       // LDM R3
    c = idle_c(); c.muxb = 2'b11; c.arf_fun = 3'b010; c.arf_reg = 3'b100;
    put(8'h06, 16'hE020, c);                       // BNZ 0x20 (taken)
    put(8'h20, 16'hE030, idle_c());                // BNZ 0x30 (not taken)
    c = idle_c(); c.muxa = 2'b11; c.rf_fun = 3'b010; c.rf_reg = 4'b0001;
    put(8'h22, 16'h43FF, c);                       // LDI R4,FF
    put(8'h24, 16'hC000, idle_c());                // HALT

    #22;
    chk("reset_ctl", 64'(act()), 64'(idle_c()));
    chk("reset_busy", 64'(Busy), 64'd0);
    chk("reset_halted", 64'(Halted), 64'd0);
    chk("reset_count", 64'(InstrCount), 64'd0);
    @(posedge Clock); #1;
    Reset = 1'b1;
    tick();
    chk("idle_no_start", 64'(act()), 64'(idle_c()));

    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("init_ctl", 64'(act()), 64'(init_c));
    chk("init_busy", 64'(Busy), 64'd0);
    tick();

    run_instr(4'b0000);
    run_instr(4'b0000);
    run_instr(4'b0000);
    run_instr(4'b0000);
    run_instr(4'b1000);
    run_instr(4'b0000);
    run_instr(4'b0000);
    chk("halt_halted", 64'(Halted), 64'd1);
    chk("halt_busy", 64'(Busy), 64'd0);
    chk("halt_ctl", 64'(act()), 64'(idle_c()));
    chk("halt_count", 64'(InstrCount), 64'd7);
    tick();
    chk("halt_hold", 64'(Halted), 64'd1);

    // Restart from HALT, then Start in FETCH_L must be ignored
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("restart_init_ctl", 64'(act()), 64'(init_c));
    chk("restart_halted", 64'(Halted), 64'd0);
    tick();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    c = idle_c(); c.ir_wr = 1'b1; c.mem_cs = 1'b0; c.arf_reg = 3'b100;
    c.arf_fun = 3'b001; c.ir_lh = 1'b1;
    chk("start_ignored_fetch_h", 64'(act()), 64'(c));

    // Asynchronous reset in the middle of FETCH_H
    #2;
    Reset = 1'b0;
    ir_m = 16'h0000; pc_m = 8'h00; IROut = 16'h0000;
    #1;
    chk("async_reset_ctl", 64'(act()), 64'(idle_c()));
    chk("async_reset_busy", 64'(Busy), 64'd0);
    tick();
    chk("reset_edge_ctl", 64'(act()), 64'(idle_c()));
    chk("reset_edge_cs", 64'(Mem_CS), 64'd1);
    chk("reset_edge_irw", 64'(IR_Write), 64'd0);
    chk("reset_edge_busy", 64'(Busy), 64'd0);
    chk("reset_edge_count", 64'(InstrCount), 64'd0);
    Reset = 1'b1;

    // Counter wrap: BNZ-to-self loop
    mem[0] = 8'h00; mem[1] = 8'hE0;
    FlagsOut = 4'b0000;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    repeat (4 * ((1 << CW) - 1)) tick();
    chk("wrap_pre_count", 64'(InstrCount), 64'((1 << CW) - 1));
    for (int k = 0; k < 4; k++) begin
      chk("wrap_busy", 64'(Busy), 64'd1);
      tick();
    end
    chk("wrap_count", 64'(InstrCount), 64'd0);
    chk("wrap_busy_after", 64'(Busy), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
